// File: rtl/axis_interleaved_accumulator_pkg.sv
// Shared helpers for the interleaved accumulator: output width, sample extension, rounding bias.
// Macro AXIS_INTERLEAVED_ACCUMULATOR_ROUNDING_EN selects round-half-up averaging instead of floor.
package axis_interleaved_accumulator_pkg;

  function automatic int out_width(input int average, input int data_width, input int acc_count_log);
    return (average != 0) ? data_width : data_width + acc_count_log;
  endfunction

  // Fill bit used when widening a sample into the accumulator.
  function automatic logic ext_fill(input int is_signed, input logic msb);
    return (is_signed != 0) ? msb : 1'b0;
  endfunction

`ifdef AXIS_INTERLEAVED_ACCUMULATOR_ROUNDING_EN
  localparam bit ROUNDING_EN = 1'b1;
`else
  localparam bit ROUNDING_EN = 1'b0;
`endif

  function automatic int round_bias(input int acc_count_log);
    return ROUNDING_EN ? (1 << (acc_count_log - 1)) : 0;
  endfunction

endpackage

// File: rtl/axis_channel_slot_buffer.sv
// Per-channel result slots drained in channel order onto an AXIS output
// with channel index and last-channel tagging.
module axis_channel_slot_buffer #(
  parameter int CHANNELS     = 4,
  parameter int CHANNELS_LOG = 2,
  parameter int OUT_WIDTH    = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [CHANNELS_LOG-1:0] wr_channel,
  input  logic [OUT_WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0]     slot_full,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [OUT_WIDTH-1:0]    output_data,
  output logic [CHANNELS_LOG-1:0] output_channel,
  output logic                    output_last
);

  localparam logic [CHANNELS_LOG-1:0] LAST_CH = CHANNELS_LOG'(CHANNELS - 1);

  logic [CHANNELS_LOG-1:0] rd_ptr_reg;
  logic [OUT_WIDTH-1:0]    slot_data [CHANNELS];
  logic                    out_fire;

  assign out_fire = output_valid && output_ready;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
    logic                 full_reg;
    logic [OUT_WIDTH-1:0] data_reg;

    // A write never targets the slot being drained: the producer stalls on a full slot.
    always_ff @(posedge clk) begin
      if (rst) begin
        full_reg <= 1'b0;
        data_reg <= '0;
      end else if (wr_en && (wr_channel == CHANNELS_LOG'(gi))) begin
        full_reg <= 1'b1;
        data_reg <= wr_data;
      end else if (out_fire && (rd_ptr_reg == CHANNELS_LOG'(gi))) begin
        full_reg <= 1'b0;
      end
    end

    assign slot_full[gi] = full_reg;
    assign slot_data[gi] = data_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
    end else if (out_fire) begin
      rd_ptr_reg <= (rd_ptr_reg == LAST_CH) ? '0 : rd_ptr_reg + CHANNELS_LOG'(1);
    end
  end

  assign output_valid   = slot_full[rd_ptr_reg];
  assign output_data    = slot_data[rd_ptr_reg];
  assign output_channel = rd_ptr_reg;
  assign output_last    = (rd_ptr_reg == LAST_CH);

endmodule

// File: rtl/axis_interleaved_accumulator.sv
// Channel-interleaved AXIS accumulator/averager: 2^ACC_COUNT_LOG samples per channel per block.
// Averaging rounds half-up when AXIS_INTERLEAVED_ACCUMULATOR_ROUNDING_EN is defined.
module axis_interleaved_accumulator
  import axis_interleaved_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int CHANNELS      = 4,
  parameter int CHANNELS_LOG  = 2,
  parameter int ACC_COUNT_LOG = 8,
  parameter int IS_SIGNED     = 0,
  parameter int AVERAGE       = 0,
  localparam int OUT_WIDTH    = out_width(AVERAGE, DATA_WIDTH, ACC_COUNT_LOG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [DATA_WIDTH-1:0]   input_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [OUT_WIDTH-1:0]    output_data,
  output logic [CHANNELS_LOG-1:0] output_channel,
  output logic                    output_last
);

  localparam int ACC_W = DATA_WIDTH + ACC_COUNT_LOG;
  localparam logic [CHANNELS_LOG-1:0] LAST_CH = CHANNELS_LOG'(CHANNELS - 1);

  logic [CHANNELS_LOG-1:0]  ch_cnt_reg;
  logic [ACC_COUNT_LOG-1:0] round_cnt_reg;
  logic [ACC_W-1:0]         acc_vec [CHANNELS];
  logic [CHANNELS-1:0]      slot_full;
  logic                     final_round;
  logic                     in_fire;
  logic [ACC_W-1:0]         sample_ext;
  logic [ACC_W-1:0]         acc_sum;
  logic [OUT_WIDTH-1:0]     result;

  assign final_round = &round_cnt_reg;
  assign input_ready = !rst && !(final_round && slot_full[ch_cnt_reg]);
  assign in_fire     = input_valid && input_ready;
  assign sample_ext  = {{ACC_COUNT_LOG{ext_fill(IS_SIGNED, input_data[DATA_WIDTH-1])}}, input_data};
  assign acc_sum     = acc_vec[ch_cnt_reg] + sample_ext;

  // The biased sum cannot overflow ACC_W, so keeping the upper DATA_WIDTH bits is
  // the same as an arithmetic/logical shift followed by truncation.
  if (AVERAGE != 0) begin : g_avg
    localparam logic [ACC_W-1:0] BIAS = ACC_W'(round_bias(ACC_COUNT_LOG));
    logic [ACC_W-1:0] acc_biased;
    assign acc_biased = acc_sum + BIAS;
    assign result     = OUT_WIDTH'(acc_biased >> ACC_COUNT_LOG);
  end else begin : g_sum
    assign result = acc_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_reg    <= '0;
      round_cnt_reg <= '0;
    end else if (in_fire) begin
      if (ch_cnt_reg == LAST_CH) begin
        ch_cnt_reg    <= '0;
        round_cnt_reg <= round_cnt_reg + ACC_COUNT_LOG'(1);
      end else begin
        ch_cnt_reg <= ch_cnt_reg + CHANNELS_LOG'(1);
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_acc
    logic [ACC_W-1:0] acc_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_reg <= '0;
      end else if (in_fire && (ch_cnt_reg == CHANNELS_LOG'(gi))) begin
        acc_reg <= final_round ? '0 : acc_sum;
      end
    end

    assign acc_vec[gi] = acc_reg;
  end

  axis_channel_slot_buffer #(
    .CHANNELS     (CHANNELS),
    .CHANNELS_LOG (CHANNELS_LOG),
    .OUT_WIDTH    (OUT_WIDTH)
  ) u_slots (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (in_fire && final_round),
    .wr_channel     (ch_cnt_reg),
    .wr_data        (result),
    .slot_full      (slot_full),
    .output_valid   (output_valid),
    .output_ready   (output_ready),
    .output_data    (output_data),
    .output_channel (output_channel),
    .output_last    (output_last)
  );

endmodule

// File: tb/tb_axis_interleaved_accumulator.sv
// Bench for axis_interleaved_accumulator: sum, unsigned-average and signed-average instances
// share handshakes; a queue model checks every cycle, literal tables pin the scenarios.
module tb_axis_interleaved_accumulator;

`ifdef AXIS_INTERLEAVED_ACCUMULATOR_ROUNDING_EN
  localparam int RB = 2;
`else
  localparam int RB = 0;
`endif
  localparam int TIMEOUT = 400;

  typedef struct { int data; int ch; bit last; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] in_data_c = '0;

  logic in_ready_a, out_valid_a, out_last_a;
  logic [17:0] out_data_a;
  logic [1:0] out_ch_a;
  logic in_ready_b, out_valid_b, out_last_b;
  logic [15:0] out_data_b;
  logic [1:0] out_ch_b;
  logic in_ready_c, out_valid_c, out_last_c;
  logic [15:0] out_data_c;
  logic [1:0] out_ch_c;

  int n_pass = 0;
  int n_total = 0;
  int m_idx = 0;
  int m_sum [4];
  int exp_q [$];
  int exp_ch_q [$];
  res_t res_a [$];
  res_t res_b [$];
  int res_c [$];
  bit rand_mode = 1'b0;
  bit bp_done = 1'b0;

  always #5 clk = ~clk;

  axis_interleaved_accumulator #(.DATA_WIDTH(16), .CHANNELS(4), .CHANNELS_LOG(2),
    .ACC_COUNT_LOG(2), .IS_SIGNED(0), .AVERAGE(0)) dut_a (
    .clk(clk), .rst(rst), .input_valid(in_valid), .input_ready(in_ready_a),
    .input_data(in_data), .output_valid(out_valid_a), .output_ready(out_ready),
    .output_data(out_data_a), .output_channel(out_ch_a), .output_last(out_last_a));

  axis_interleaved_accumulator #(.DATA_WIDTH(16), .CHANNELS(4), .CHANNELS_LOG(2),
    .ACC_COUNT_LOG(2), .IS_SIGNED(0), .AVERAGE(1)) dut_b (
    .clk(clk), .rst(rst), .input_valid(in_valid), .input_ready(in_ready_b),
    .input_data(in_data), .output_valid(out_valid_b), .output_ready(out_ready),
    .output_data(out_data_b), .output_channel(out_ch_b), .output_last(out_last_b));

  axis_interleaved_accumulator #(.DATA_WIDTH(16), .CHANNELS(4), .CHANNELS_LOG(2),
    .ACC_COUNT_LOG(2), .IS_SIGNED(1), .AVERAGE(1)) dut_c (
    .clk(clk), .rst(rst), .input_valid(in_valid), .input_ready(in_ready_c),
    .input_data(in_data_c), .output_valid(out_valid_c), .output_ready(out_ready),
    .output_data(out_data_c), .output_channel(out_ch_c), .output_last(out_last_c));

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: sample n belongs to channel n%4 and round (n/4)%4; a result
  // exists from the end of its block until it is drained, in completion order.
  always @(negedge clk) begin : model
    int ch, rnd, avg, head_ch;
    bit exp_ready, exp_valid, ok, busy;
    if (rst) begin
      check(in_ready_a == 1'b0, "ready_in_reset", in_ready_a, 0);
      m_idx = 0;
      for (int i = 0; i < 4; i++) m_sum[i] = 0;
      exp_q.delete();
      exp_ch_q.delete();
    end else begin
      ch = m_idx % 4;
      rnd = (m_idx / 4) % 4;
      busy = 1'b0;
      foreach (exp_ch_q[i]) if (exp_ch_q[i] == ch) busy = 1'b1;
      exp_ready = !(rnd == 3 && busy);
      exp_valid = exp_q.size() > 0;
      ok = (in_ready_a == exp_ready) && (in_ready_b == exp_ready) && (in_ready_c == exp_ready)
        && (out_valid_a == exp_valid) && (out_valid_b == exp_valid) && (out_valid_c == exp_valid);
      avg = 0;
      head_ch = 0;
      if (exp_valid) begin
        avg = (exp_q[0] + RB) >> 2;
        head_ch = exp_ch_q[0];
        ok = ok && (int'(out_data_a) == exp_q[0]) && (int'(out_ch_a) == head_ch)
          && (out_last_a == (head_ch == 3)) && (int'(out_data_b) == avg)
          && (int'(out_ch_b) == head_ch) && (out_last_b == (head_ch == 3))
          && (int'(out_ch_c) == head_ch);
      end
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL cycle t=%0t: got rdy=%b vld=%b sum=%0d ch=%0d last=%b avg=%0d, expected rdy=%b vld=%b sum=%0d ch=%0d avg=%0d",
                    $time, in_ready_a, out_valid_a, out_data_a, out_ch_a, out_last_a, out_data_b,
                    exp_ready, exp_valid, exp_valid ? exp_q[0] : 0, head_ch, avg);
      if (out_valid_a && out_ready) begin
        res_a.push_back('{int'(out_data_a), int'(out_ch_a), out_last_a});
        res_b.push_back('{int'(out_data_b), int'(out_ch_b), out_last_b});
      end
      if (out_valid_c && out_ready) res_c.push_back(int'(out_data_c));
      if (exp_valid && out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_ch_q.pop_front());
      end
      if (in_valid && exp_ready) begin
        m_sum[ch] += int'(in_data);
        m_idx++;
        if (rnd == 3) begin
          exp_q.push_back(m_sum[ch]);
          exp_ch_q.push_back(ch);
          m_sum[ch] = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] dc);
    int t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_data_c = dc;
    forever begin
      @(negedge clk);
      if (in_ready_a) break;
      t++;
      if (t > TIMEOUT) begin
        check(1'b0, "send_timeout", t, TIMEOUT);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_ramp(input int n);
    for (int i = 0; i < n; i++) send(16'(i), 16'(i));
  endtask

  task automatic check_block(input string name, input int first, input int step);
    check(res_a.size() == 4, {name, "_count"}, res_a.size(), 4);
    for (int i = 0; i < 4 && i < res_a.size(); i++) begin
      check(res_a[i].data == first + step * i && res_a[i].ch == i && res_a[i].last == (i == 3),
            {name, "_sum"}, res_a[i].data, first + step * i);
      check(res_b[i].data == (first + step * i + RB) / 4, {name, "_avg"}, res_b[i].data,
            (first + step * i + RB) / 4);
    end
  endtask

  initial begin
    int base, t;
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(out_valid_a == 1'b0, "rst_valid", out_valid_a, 0);
    check(out_data_a == '0, "rst_data", out_data_a, 0);
    check(out_ch_a == '0, "rst_channel", out_ch_a, 0);
    check(out_last_a == 1'b0, "rst_last", out_last_a, 0);
    check(in_ready_a == 1'b1, "rst_ready_after", in_ready_a, 1);
    wait_cycles(1);

    // Ramp 0..15 with output always ready: 24,28,32,36 / 6,7,8,9
    out_ready = 1'b1;
    send_ramp(16);
    wait_cycles(6);
    check_block("ramp", 24, 4);
    check(res_b.size() == 4 && res_b[0].data == 6 && res_b[3].data == 9, "ramp_avg_ends",
          res_b.size() > 3 ? res_b[3].data : -1, 9);

    // Rounding: ch0 gets 1,1,2,2 (signed copy -1,-1,-2,-2), others zero
    res_a.delete(); res_b.delete(); res_c.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        logic [15:0] d;
        d = (c == 0) ? ((r < 2) ? 16'd1 : 16'd2) : 16'd0;
        send(d, -d);
      end
    wait_cycles(6);
    check(res_b.size() == 4 && res_b[0].data == ((RB != 0) ? 2 : 1), "round_unsigned",
          res_b.size() > 0 ? res_b[0].data : -1, (RB != 0) ? 2 : 1);
    check(res_c.size() == 4 && res_c[0] == ((RB != 0) ? 32'h0000FFFF : 32'h0000FFFE),
          "round_signed", res_c.size() > 0 ? res_c[0] : -1,
          (RB != 0) ? 32'h0000FFFF : 32'h0000FFFE);

    // Back-pressure: 32 ramp samples with output stalled
    res_a.delete(); res_b.delete();
    out_ready = 1'b0;
    base = m_idx;
    fork
      begin
        send_ramp(32);
        bp_done = 1'b1;
      end
    join_none
    t = 0;
    while ((m_idx - base) < 28 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    wait_cycles(4);
    @(negedge clk);
    check((m_idx - base) == 28, "bp_accepted", m_idx - base, 28);
    check(in_ready_a == 1'b0, "bp_ready_low", in_ready_a, 0);
    check(out_valid_a == 1'b1 && out_data_a == 18'd24, "bp_head", out_data_a, 24);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check(in_ready_a == 1'b0, "bp_ready_still_low", in_ready_a, 0);
    @(negedge clk);
    check(in_ready_a == 1'b1, "bp_ready_return", in_ready_a, 1);
    t = 0;
    while (!bp_done && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check(bp_done, "bp_stream_done", bp_done, 1);
    wait_cycles(8);
    check(res_a.size() == 8, "bp_count", res_a.size(), 8);
    for (int i = 0; i < 8 && i < res_a.size(); i++)
      check(res_a[i].data == ((i < 4) ? 24 + 4 * i : 88 + 4 * (i - 4)) && res_a[i].ch == i % 4,
            "bp_sum", res_a[i].data, (i < 4) ? 24 + 4 * i : 88 + 4 * (i - 4));

    // Random valid/ready over 1000 ramp samples
    res_a.delete(); res_b.delete();
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 2));
      send(16'(i), 16'(i));
    end
    rand_mode = 1'b0;
    wait_cycles(1);
    out_ready = 1'b1;
    wait_cycles(20);
    check(res_a.size() == 248, "rand_count", res_a.size(), 248);
    check(exp_q.size() == 0, "rand_drained", exp_q.size(), 0);

    // Reset mid-block with undrained results pending
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(16'(100 + i), 16'(100 + i));
    wait_cycles(2);
    check(out_valid_a == 1'b1, "pre_rst_pending", out_valid_a, 1);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    @(negedge clk);
    check(out_valid_a == 1'b0 && out_data_a == '0 && out_ch_a == '0 && out_last_a == 1'b0,
          "mid_rst_outputs", out_data_a, 0);
    check(in_ready_a == 1'b1, "mid_rst_ready", in_ready_a, 1);
    wait_cycles(1);
    res_a.delete(); res_b.delete();
    out_ready = 1'b1;
    send_ramp(16);
    wait_cycles(6);
    check_block("post_rst", 24, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_interleaved_accumulator.md
# axis_interleaved_accumulator

Multi-channel successor to the single-stream AXIS accumulator/averager processing elements. It takes one channel-interleaved AXIS input stream (ch0, ch1, …, ch(CHANNELS-1), ch0, …) and accumulates 2^ACC_COUNT_LOG samples per channel. It emits one sum or average per channel per block, in channel order, tagged with channel index and last flag. Per-channel result slots let block N drain while block N+1 accumulates. It sits between a band/pixel generator and downstream statistics or prediction stages.

## Interface
- DATA_WIDTH, 16, input sample width
- CHANNELS, 4, interleaved channel count (≥2)
- CHANNELS_LOG, 2, ceil(log2(CHANNELS))
- ACC_COUNT_LOG, 8, log2 of samples per channel per block (≥1)
- IS_SIGNED, 0, 1 = two's-complement samples and arithmetic
- AVERAGE, 0, 0 = output full sum, 1 = output sum >> ACC_COUNT_LOG
- Derived OUT_WIDTH = AVERAGE ? DATA_WIDTH : DATA_WIDTH+ACC_COUNT_LOG
- One clock; reset is synchronous and active-high. Ports `clk`, `rst`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- input_valid  in  1  sample valid
- input_ready  out  1  sample accepted when valid&ready
- input_data  in  DATA_WIDTH  sample
- output_valid  out  1  result valid
- output_ready  in  1  downstream ready
- output_data  out  OUT_WIDTH  sum or average
- output_channel  out  CHANNELS_LOG  channel of current result
- output_last  out  1  high with channel CHANNELS-1 result

## Operation
- Counters: ch_cnt (0..CHANNELS-1) and round_cnt (0..2^ACC_COUNT_LOG-1). They advance only on input handshake. ch_cnt wraps to 0 and increments round_cnt. round_cnt wraps to 0 after the final round.
- Accumulator acc[c] is DATA_WIDTH+ACC_COUNT_LOG bits, sign- or zero-extended per IS_SIGNED. Overflow is impossible by construction.
- Non-final round, accept: acc[ch_cnt] <= acc[ch_cnt] + ext(data).
- Final round, accept: slot[ch_cnt] <= scale(acc[ch_cnt] + ext(data)), slot_full[ch_cnt] <= 1, acc[ch_cnt] <= 0.
- scale: identity if AVERAGE=0. If AVERAGE=1, shift right ACC_COUNT_LOG (arithmetic when IS_SIGNED) and take the low DATA_WIDTH bits (see Configuration).
- input_ready = !rst && !(round_cnt is final && slot_full[ch_cnt]). The check uses the registered slot_full only; there is no bypass from a same-cycle drain.
- Drain pointer rd_ptr (0..CHANNELS-1):
  - output_valid = slot_full[rd_ptr]; output_data = slot[rd_ptr]; output_channel = rd_ptr; output_last = (rd_ptr == CHANNELS-1).
  - On output handshake: slot_full[rd_ptr] <= 0 and rd_ptr wraps-increments.
- If one cycle has a write to slot c and a drain from a different slot d, both happen. A write to the slot being drained cannot occur, because input_ready is low for a full slot.

## Timing
- Reset values: all counters 0, acc 0, slot_full 0, rd_ptr 0, output_valid 0, output_data 0, output_channel 0, output_last 0. input_ready is 0 while rst is high and 1 in the first cycle after.
- Latency: the final-round sample for channel c is accepted at edge k. slot c becomes valid after edge k. It is presented at the output the same cycle if rd_ptr == c.
- Throughput is 1 sample/cycle when the output is always ready. Steady-state output is CHANNELS results per CHANNELS·2^ACC_COUNT_LOG inputs.
- Outputs hold stable while output_valid & !output_ready (AXIS rule).
- Reset mid-block discards partial sums and undrained results. There is no partial-block output.

## Configuration
- Macro `AXIS_INTERLEAVED_ACCUMULATOR_ROUNDING_EN`. It has effect only when AVERAGE=1.
- Defined: add 2^(ACC_COUNT_LOG-1) before the shift (round half toward +∞, signed and unsigned).
- Undefined: plain shift (floor).

## Structure
- The shared package holds:
  - an out_width function (AVERAGE, DATA_WIDTH, ACC_COUNT_LOG)
  - an ext/scale helper parameterised by IS_SIGNED
  - the rounding-bias constant
- One natural sub-module: `axis_channel_slot_buffer` (CHANNELS result slots, full bits, rd_ptr, output handshake, channel/last tagging).
- Counters and accumulators stay in the top.

## Test plan
- CHANNELS=4, ACC_COUNT_LOG=2, AVERAGE=0, unsigned, input ramp 0..15, output always ready -> results 24,28,32,36 with channels 0..3, output_last only on 36.
- Same stimulus with AVERAGE=1 -> 6,7,8,9.
- AVERAGE=1, ch0 samples 1,1,2,2 (others 0): unsigned -> 2 with the macro, 1 without. With IS_SIGNED=1, ch0 samples -1,-1,-2,-2 -> -1 with the macro, -2 without.
- Back-pressure: output_ready held 0, stream 32 ramp samples.
  - Block 1 fills all slots; block 2 rounds 0–2 are accepted.
  - input_ready drops at block-2 ch0 final sample.
  - Raising output_ready drains 24,28,32,36; input_ready returns after the ch0 slot frees.
  - Block 2 yields 88,92,96,100.
- Random valid/ready toggling over 1000 ramp samples -> every result matches the reference model sum and no result is lost or duplicated.
- rst pulsed after 9 accepted samples -> outputs zero, input_ready 1. A fresh ramp 0..15 gives 24,28,32,36.
